// File: rtl/cpu_mc_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_mc_core: multi-cycle FETCH/EXEC CPU with a valid/ready fetch port     |
// | and a registered retire port.                                             |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module cpu_mc_core #(
  parameter int          DATA_W   = 8,
  parameter int          REG_N    = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  localparam int         RA_W     = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_valid,
  input  logic [31:0]       imem_instr,
  output logic              halted,
  output logic              illegal,
  output logic              retire_valid,
  output logic [31:0]       retire_pc,
  output logic              retire_wr_en,
  output logic [RA_W-1:0]   retire_rd,
  output logic [DATA_W-1:0] retire_data
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [7:0] c_op_loadi = 8'h00;
  localparam logic [7:0] c_op_mov   = 8'h01;
  localparam logic [7:0] c_op_add   = 8'h02;
  localparam logic [7:0] c_op_sub   = 8'h03;
  localparam logic [7:0] c_op_and   = 8'h04;
  localparam logic [7:0] c_op_or    = 8'h05;
  localparam logic [7:0] c_op_j     = 8'h06;
  localparam logic [7:0] c_op_beq   = 8'h07;
  localparam logic [7:0] c_op_halt  = 8'h08;

  state_t            r_state;
  logic              r_req;
  logic [31:0]       r_pc;
  logic [31:0]       r_ir;
  logic [DATA_W-1:0] r_regs [REG_N];
  logic              r_halted;
  logic              r_illegal;
  logic              r_ret_valid;
  logic [31:0]       r_ret_pc;
  logic              r_ret_wr;
  logic [RA_W-1:0]   r_ret_rd;
  logic [DATA_W-1:0] r_ret_data;

  logic [7:0]        w_op;
  logic [RA_W-1:0]   w_rd;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_imm;
  logic [31:0]       w_off;
  logic [31:0]       w_target;
  logic              w_wr;
  logic [DATA_W-1:0] w_data;
  logic [31:0]       w_pc_next;
  logic              w_stop;
  logic              w_ill;
  logic              w_unused_fields;

  assign w_op     = r_ir[31:24];
  assign w_rd     = r_ir[16 +: RA_W];
  assign w_a      = r_regs[r_ir[8 +: RA_W]];
  assign w_b      = r_regs[r_ir[0 +: RA_W]];
  assign w_imm    = DATA_W'($signed(r_ir[7:0]));
  assign w_off    = 32'($signed(r_ir[23:16]));
  assign w_target = r_pc + 32'd4 + (w_off << 2);
  // Register-index fields may be wider than RA_W; the surplus bits are don't-care.
  assign w_unused_fields = ^{r_ir[15:8], r_ir[7:0]};

  always_comb begin
    w_wr      = 1'b0;
    w_data    = '0;
    w_pc_next = r_pc + 32'd4;
    w_stop    = 1'b0;
    w_ill     = 1'b0;
    case (w_op)
      c_op_loadi: begin w_wr = 1'b1; w_data = w_imm;       end
      c_op_mov:   begin w_wr = 1'b1; w_data = w_b;         end
      c_op_add:   begin w_wr = 1'b1; w_data = w_a + w_b;   end
      c_op_sub:   begin w_wr = 1'b1; w_data = w_a - w_b;   end
      c_op_and:   begin w_wr = 1'b1; w_data = w_a & w_b;   end
      c_op_or:    begin w_wr = 1'b1; w_data = w_a | w_b;   end
      c_op_j:     w_pc_next = w_target;
      c_op_beq:   if (w_a == w_b) w_pc_next = w_target;
      c_op_halt:  w_stop = 1'b1;
      default:    begin w_stop = 1'b1; w_ill = 1'b1; end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_FETCH;
      r_req       <= 1'b0;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_halted    <= 1'b0;
      r_illegal   <= 1'b0;
      r_ret_valid <= 1'b0;
      r_ret_pc    <= '0;
      r_ret_wr    <= 1'b0;
      r_ret_rd    <= '0;
      r_ret_data  <= '0;
      for (int i = 0; i < REG_N; i++) r_regs[i] <= '0;
    end else begin
      r_ret_valid <= 1'b0;
      case (r_state)
        ST_FETCH: begin
          // The request only counts once it has been visible for a cycle.
          if (r_req && imem_valid) begin
            r_ir    <= imem_instr;
            r_req   <= 1'b0;
            r_state <= ST_EXEC;
          end else begin
            r_req <= 1'b1;
          end
        end
        ST_EXEC: begin
          r_ret_valid <= 1'b1;
          r_ret_pc    <= r_pc;
          r_ret_wr    <= w_wr;
          if (w_wr) begin
            r_ret_rd   <= w_rd;
            r_ret_data <= w_data;
          end
          if (w_stop) begin
            r_state   <= ST_HALT;
            r_halted  <= 1'b1;
            r_illegal <= w_ill;
          end else begin
            if (w_wr) r_regs[w_rd] <= w_data;
            r_pc    <= w_pc_next;
            r_req   <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_HALT: r_req <= 1'b0;
        default: r_state <= ST_HALT;
      endcase
    end
  end

  assign imem_req     = r_req;
  assign imem_addr    = r_pc;
  assign halted       = r_halted;
  assign illegal      = r_illegal;
  assign retire_valid = r_ret_valid;
  assign retire_pc    = r_ret_pc;
  assign retire_wr_en = r_ret_wr;
  assign retire_rd    = r_ret_rd;
  assign retire_data  = r_ret_data;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mc_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_cpu_mc_core: randomized programs against an ISA-level model with a    |
// | retire scoreboard, plus directed branch/stall/stop/reset scenarios.       |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
module tb_cpu_mc_core;

  localparam int DW = 16;
  localparam int RN = 8;

  typedef struct {
    logic [31:0]   pc;
    logic          wr;
    logic [2:0]    rd;
    logic [DW-1:0] data;
    logic          halt;
    logic          ill;
  } rec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_valid;
  logic [31:0]   imem_instr;
  logic          halted;
  logic          illegal;
  logic          retire_valid;
  logic [31:0]   retire_pc;
  logic          retire_wr_en;
  logic [2:0]    retire_rd;
  logic [DW-1:0] retire_data;

  cpu_mc_core #(.DATA_W(DW), .REG_N(RN), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_instr(imem_instr),
    .halted(halted), .illegal(illegal),
    .retire_valid(retire_valid), .retire_pc(retire_pc),
    .retire_wr_en(retire_wr_en), .retire_rd(retire_rd),
    .retire_data(retire_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int wait_fixed = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] prog [$];
  rec_t exp_q [$];
  int ret_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] rd,
                                      input logic [7:0] rs1, input logic [7:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  // Unwritten addresses read back as HALT so stray jumps terminate.
  function automatic logic [31:0] fetch(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0800_0000;
  endfunction

  // Instruction-set interpreter: walks the program and queues one record per retire.
  function automatic void run_model(input int max_steps);
    logic [DW-1:0] rf [RN];
    logic [31:0]   pc, npc, w;
    logic [DW-1:0] a, b;
    int s, o;
    rec_t e;
    foreach (rf[i]) rf[i] = '0;
    pc = 32'h0;
    for (int k = 0; k < max_steps; k++) begin
      w = fetch(pc);
      a = rf[w[10:8]];
      b = rf[w[2:0]];
      s = int'(w[7:0]);   if (s > 127) s -= 256;
      o = int'(w[23:16]); if (o > 127) o -= 256;
      npc = pc + 32'd4;
      e.pc = pc; e.wr = 1'b1; e.rd = w[18:16]; e.data = '0; e.halt = 1'b0; e.ill = 1'b0;
      case (w[31:24])
        8'h00: e.data = DW'(s);
        8'h01: e.data = b;
        8'h02: e.data = a + b;
        8'h03: e.data = a - b;
        8'h04: e.data = a & b;
        8'h05: e.data = a | b;
        8'h06: begin e.wr = 1'b0; npc = pc + 32'(4 + 4 * o); end
        8'h07: begin e.wr = 1'b0; if (a == b) npc = pc + 32'(4 + 4 * o); end
        8'h08: begin e.wr = 1'b0; e.halt = 1'b1; end
        default: begin e.wr = 1'b0; e.halt = 1'b1; e.ill = 1'b1; end
      endcase
      if (e.wr) rf[e.rd] = e.data;
      exp_q.push_back(e);
      if (e.halt) return;
      pc = npc;
    end
  endfunction

  // Instruction memory with configurable (or random) wait states; noise on
  // imem_valid whenever no request is pending.
  int wcnt = 0, wtarget = 0;
  initial begin
    imem_valid = 1'b0;
    imem_instr = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst) begin
        imem_valid = 1'b0;
        wcnt = 0;
        wtarget = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 2));
      end else if (!imem_req) begin
        imem_valid = 1'($urandom_range(0, 1));
        imem_instr = $urandom;
      end else if (wcnt < wtarget) begin
        imem_valid = 1'b0;
        wcnt++;
      end else begin
        imem_valid = 1'b1;
        imem_instr = fetch(imem_addr);
        wcnt = 0;
        wtarget = (wait_fixed >= 0) ? wait_fixed : int'($urandom_range(0, 2));
      end
    end
  end

  // Monitor: scoreboard pop on every retire pulse, plus fetch-hold checks.
  rec_t mon_e;
  logic prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_req = 1'b0;
    end else begin
      if (retire_valid) begin
        ret_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_retire_pc", 64'(retire_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          chk("retire_pc", 64'(retire_pc), 64'(mon_e.pc));
          chk("retire_wr_en", 64'(retire_wr_en), 64'(mon_e.wr));
          if (mon_e.wr) begin
            chk("retire_rd", 64'(retire_rd), 64'(mon_e.rd));
            chk("retire_data", 64'(retire_data), 64'(mon_e.data));
          end
          chk("halted_at_retire", 64'(halted), 64'(mon_e.halt));
          chk("illegal_at_retire", 64'(illegal), 64'(mon_e.ill));
        end
      end
      if (prev_req && !imem_valid) begin
        chk("stall_req_held", 64'(imem_req), 64'd1);
        chk("stall_addr_held", 64'(imem_addr), 64'(prev_addr));
      end
      prev_req = imem_req;
      prev_addr = imem_addr;
    end
  end

  task automatic start_prog(input int steps);
    @(negedge clk); #2;
    rst = 1'b0;
    mem.delete();
    foreach (prog[i]) mem[32'(i * 4)] = prog[i];
    exp_q.delete();
    ret_cyc.delete();
    run_model(steps);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic wait_done(input string nm, input logic exp_ill);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk); #4;
      if (halted && exp_q.size() == 0) break;
    end
    if (k == 400) chk({nm, "_timeout"}, 64'(exp_q.size()), 64'd0);
    repeat (6) @(negedge clk);
    #4;
    chk({nm, "_halt_req_low"}, 64'(imem_req), 64'd0);
    chk({nm, "_halted"}, 64'(halted), 64'd1);
    chk({nm, "_illegal"}, 64'(illegal), 64'(exp_ill));
  endtask

  task automatic gen_random;
    int n, r;
    logic [7:0] op;
    prog.delete();
    n = $urandom_range(6, 14);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) op = 8'(r);
      else if (r <= 7) op = 8'(r);
      else op = 8'($urandom_range(2, 5));
      if (op == 8'h06 || op == 8'h07)
        prog.push_back(ins(op, 8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom)));
      else
        prog.push_back(ins(op, 8'($urandom), 8'($urandom), 8'($urandom)));
    end
    if ($urandom_range(0, 3) == 0)
      prog.push_back({8'($urandom_range(9, 255)), 24'($urandom)});
    else
      prog.push_back(32'h0800_0000);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    rst = 1'b0;
    #1;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_illegal", 64'(illegal), 64'd0);
    chk("rst_retire_valid", 64'(retire_valid), 64'd0);
    chk("rst_retire_pc", 64'(retire_pc), 64'd0);
    chk("rst_retire_wr_en", 64'(retire_wr_en), 64'd0);
    chk("rst_retire_rd", 64'(retire_rd), 64'd0);
    chk("rst_retire_data", 64'(retire_data), 64'd0);

    // Zero-wait arithmetic sequence, one retire every two cycles.
    wait_fixed = 0;
    prog = '{ins(8'h00, 8'd1, 8'd0, 8'd5), ins(8'h00, 8'd2, 8'd0, 8'd3),
             ins(8'h02, 8'd3, 8'd1, 8'd2), ins(8'h03, 8'd4, 8'd2, 8'd1),
             32'h0800_0000};
    start_prog(64);
    wait_done("zero_wait", 1'b0);
    chk("zero_wait_retires", 64'(ret_cyc.size()), 64'd5);
    for (int i = 0; i + 1 < ret_cyc.size(); i++)
      chk("zero_wait_spacing", 64'(ret_cyc[i+1] - ret_cyc[i]), 64'd2);

    // Sign extension and 16-bit logic ops.
    wait_fixed = -1;
    prog = '{ins(8'h00, 8'd1, 8'd0, 8'hFF), ins(8'h02, 8'd2, 8'd1, 8'd1),
             ins(8'h00, 8'd3, 8'd0, 8'h5A), ins(8'h04, 8'd4, 8'd2, 8'd3),
             ins(8'h05, 8'd5, 8'd3, 8'd4), ins(8'h01, 8'd6, 8'd0, 8'd2),
             ins(8'h00, 8'd7, 8'd0, 8'h80), ins(8'h05, 8'hF0, 8'hE7, 8'hCB),
             32'h0800_0000};
    start_prog(64);
    wait_done("width", 1'b0);

    // BEQ taken (8 -> 20), J -3 (20 -> 12), then BEQ not taken.
    for (int t = 0; t < 2; t++) begin
      prog = '{ins(8'h00, 8'd1, 8'd0, 8'd7), ins(8'h00, 8'd2, 8'd0, (t == 0) ? 8'd7 : 8'd6),
               ins(8'h07, 8'd2, 8'd1, 8'd2), 32'h0800_0000,
               ins(8'h00, 8'd5, 8'd0, 8'd1), ins(8'h06, 8'hFD, 8'd0, 8'd0)};
      start_prog(64);
      wait_done("branch", 1'b0);
      chk("branch_retires", 64'(ret_cyc.size()), (t == 0) ? 64'd5 : 64'd4);
    end

    // Three wait states per fetch: five cycles per instruction.
    wait_fixed = 3;
    prog = '{ins(8'h00, 8'd1, 8'd0, 8'd1), ins(8'h00, 8'd2, 8'd0, 8'd2), 32'h0800_0000};
    start_prog(64);
    wait_done("stall", 1'b0);
    for (int i = 0; i + 1 < ret_cyc.size(); i++)
      chk("stall_spacing", 64'(ret_cyc[i+1] - ret_cyc[i]), 64'd5);

    // Illegal opcode stops the core.
    wait_fixed = -1;
    prog = '{ins(8'h00, 8'd1, 8'd0, 8'd9), ins(8'h3F, 8'd1, 8'd1, 8'd1), ins(8'h00, 8'd1, 8'd0, 8'd2)};
    start_prog(64);
    wait_done("illegal_op", 1'b1);

    // Asynchronous reset while ADD is executing.
    wait_fixed = 0;
    prog = '{ins(8'h00, 8'd1, 8'd0, 8'd5), ins(8'h00, 8'd2, 8'd0, 8'd3),
             ins(8'h02, 8'd3, 8'd1, 8'd2), 32'h0800_0000};
    start_prog(2);
    for (k = 0; k < 50; k++) begin
      @(negedge clk); #3;
      if (imem_req && imem_valid && imem_addr == 32'd8) break;
    end
    chk("areset_found_add", 64'(k < 50), 64'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("areset_imem_req", 64'(imem_req), 64'd0);
    chk("areset_retire_valid", 64'(retire_valid), 64'd0);
    chk("areset_retire_pc", 64'(retire_pc), 64'd0);
    chk("areset_retire_data", 64'(retire_data), 64'd0);
    chk("areset_imem_addr", 64'(imem_addr), 64'd0);
    chk("areset_pending", 64'(exp_q.size()), 64'd0);
    prog = '{ins(8'h01, 8'd4, 8'd0, 8'd3), ins(8'h02, 8'd5, 8'd1, 8'd2), 32'h0800_0000};
    mem.delete();
    foreach (prog[i]) mem[32'(i * 4)] = prog[i];
    exp_q.delete();
    ret_cyc.delete();
    run_model(64);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk); #4;
    chk("areset_first_req", 64'(imem_req), 64'd1);
    chk("areset_first_addr", 64'(imem_addr), 64'd0);
    wait_done("after_reset", 1'b0);

    // Randomized programs with random wait states.
    wait_fixed = -1;
    for (int p = 0; p < 25; p++) begin
      gen_random();
      start_prog(64);
      wait_done("random", exp_q[exp_q.size()-1].ill);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu_mc_core.md
Name: cpu_mc_core

Overview:
- Parametrised multi-cycle successor to the team's single-cycle 8-bit CPU.
- Keeps the same opcode family (loadi, mov, add, sub, and, or) and adds:
  - configurable data width and register count;
  - jump, branch-if-equal and halt;
  - a valid/ready-style instruction-fetch interface that tolerates memory wait states;
  - a registered retire/debug port for verification.
- Sits between the instruction memory and the (future) data path extensions.

Parameters:
- DATA_W, 8, register and ALU width in bits (>=8).
- REG_N, 8, number of general registers (power of two, 2..256); index width RA_W = clog2(REG_N).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; 0 resets all state immediately.
- imem_req  out  1  fetch request, held high until accepted.
- imem_addr  out  32  fetch address; equals pc while imem_req is high.
- imem_valid  in  1  instruction present this cycle; ignored when imem_req is low.
- imem_instr  in  32  instruction word; sampled when imem_req && imem_valid.
- halted  out  1  core has stopped (HALT opcode or illegal opcode).
- illegal  out  1  stop was caused by an undefined opcode.
- retire_valid  out  1  one-cycle pulse per committed instruction.
- retire_pc  out  32  PC of the retired instruction.
- retire_wr_en  out  1  retired instruction wrote a register.
- retire_rd  out  RA_W  destination register index.
- retire_data  out  DATA_W  value written.

Behaviour:
- Instruction fields:
  - opcode = [31:24]; rd = [23:16]; rs1 = [15:8]; rs2/imm = [7:0].
  - Register indices use the low RA_W bits of each field; upper bits are ignored.
  - imm is sign-extended to DATA_W.
- Opcodes:
  - 0x00 LOADI: rd = imm.
  - 0x01 MOV: rd = R[rs2].
  - 0x02 ADD: rd = R[rs1] + R[rs2].
  - 0x03 SUB: rd = R[rs1] - R[rs2].
  - 0x04 AND: rd = R[rs1] & R[rs2].
  - 0x05 OR: rd = R[rs1] | R[rs2].
  - 0x06 J: pc = pc + 4 + (sext([23:16]) << 2).
  - 0x07 BEQ: if R[rs1] == R[rs2], pc = pc + 4 + (sext([23:16]) << 2), else pc + 4; no register write.
  - 0x08 HALT.
  - Any other value is illegal.
- Arithmetic: all results are modulo 2^DATA_W; no flags or exceptions. PC arithmetic is modulo 2^32.
- Register file:
  - REG_N x DATA_W, internal, all registers cleared to 0 on reset.
  - All registers are writable; R0 is not hardwired.
- FSM states: FETCH, EXEC, HALT.
  - FETCH: imem_req=1, imem_addr=pc. On a clock edge with imem_valid=1, latch imem_instr into IR and go to EXEC. Otherwise stay; address is held stable.
  - EXEC: exactly one cycle. Decode IR, read operands, compute. On the edge leaving EXEC:
    - write rd if the opcode is a write type;
    - update pc;
    - load the retire_* registers and set retire_valid=1;
    - go to FETCH.
    - HALT or illegal opcode instead goes to HALT with pc unchanged; retire_valid=1 with retire_wr_en=0.
    - Illegal opcode additionally sets illegal=1.
  - HALT: imem_req=0 and no state changes. The only exit is reset.
- Timing:
  - Minimum 2 cycles per instruction (zero-wait memory); each imem wait cycle adds 1.
  - A register written by instruction N is visible to instruction N+1; no hazards exist.
- retire_valid is high for exactly one cycle (the first cycle of the following FETCH/HALT). Other retire_* outputs hold their last values.
- Reset values (rst=0, asynchronous):
  - pc=RESET_PC, state=FETCH, all registers 0;
  - halted=0, illegal=0, retire_valid=0, retire_wr_en=0, retire_pc=0, retire_rd=0, retire_data=0.
  - imem_req goes low while rst=0 and asserts in the first cycle after release.
- Reset mid-operation: an in-flight fetch or EXEC is abandoned with no register write and no retire pulse. A later imem_valid for the old request is not special-cased (the memory is reset together with the core).
- imem_valid while in EXEC or HALT is ignored.

Test Plan:
- Zero-wait sequence (DATA_W=8): LOADI r1,5; LOADI r2,3; ADD r3,r1,r2; SUB r4,r2,r1 -> retire_data 5,3,8,0xFE; retire_pc 0,4,8,12; one retire every 2 cycles.
- Width/wrap (DATA_W=16): LOADI r1,0xFF (sign-extends to 0xFFFF); ADD r2,r1,r1 -> r2=0xFFFE; AND/OR/MOV produce correct 16-bit values.
- Branch: r1=r2=7 then BEQ off=+2 at pc 8 -> next imem_addr 20. With r2=6 -> next imem_addr 12. J off=-3 at pc 20 -> imem_addr 12.
- Fetch stall: imem_valid held low 3 cycles -> imem_req and imem_addr stable throughout; instruction completes in 5 cycles; no retire during the stall.
- Stop: opcode 0x08 -> halted=1, illegal=0, imem_req=0 forever. Opcode 0x3F -> halted=1, illegal=1, no register changed.
- Async reset: assert rst low mid-EXEC of ADD -> outputs reset immediately; destination not written; after release imem_addr=RESET_PC.
